pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall generation, divide sequencing, exception flush
// and a saturating count of cycles in which the pc stage is held.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no divide in flight; accepts div_start or an exception
// DIV_BUSY | divide running; div_cnt counts down to the done cycle
// FLUSH    | flush=1 for one cycle; all inputs ignored
module pipe_ctrl #(
  parameter int unsigned DIV_CYCLES = 32,
  parameter logic [31:0] EXC_VECTOR = 32'h00000020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        div_start,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        div_done,
  output logic        div_busy,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {IDLE, DIV_BUSY, FLUSH} state_t;

  localparam logic [31:0] EXC_ERET = 32'h0000000e;
  localparam logic [5:0]  DIV_LOAD = 6'(DIV_CYCLES - 1);

  state_t     state, state_nxt;
  logic [5:0] div_cnt, div_cnt_nxt;
  logic       exc_hit;
  logic       enter_flush;

  assign exc_hit     = |excepttype_i;
  // FLUSH ignores inputs, so a lingering exception cannot re-arm the flush
  assign enter_flush = (state != FLUSH) && exc_hit;

  // State and divide counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= 6'd0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_cnt_nxt;
    end
  end

  // Next-state, counter update and the div_done pulse
  always_comb begin
    state_nxt   = state;
    div_cnt_nxt = div_cnt;
    div_done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (exc_hit) begin
          state_nxt   = FLUSH;
          div_cnt_nxt = 6'd0;
        end else if (div_start) begin
          state_nxt   = DIV_BUSY;
          div_cnt_nxt = DIV_LOAD;
        end
      end
      DIV_BUSY: begin
        if (exc_hit) begin
          // aborted divide: no done pulse
          state_nxt   = FLUSH;
          div_cnt_nxt = 6'd0;
        end else if (div_cnt == 6'd0) begin
          div_done  = 1'b1;
          state_nxt = IDLE;
        end else begin
          div_cnt_nxt = div_cnt - 6'd1;
        end
      end
      FLUSH: begin
        state_nxt   = IDLE;
        div_cnt_nxt = 6'd0;
      end
      default: begin
        state_nxt   = IDLE;
        div_cnt_nxt = 6'd0;
      end
    endcase
    if (rst) div_done = 1'b0;
  end

  assign div_busy = (state == DIV_BUSY) && (div_cnt != 6'd0) && !rst;

  // Registered flush and redirect target, captured with the exception
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush  <= 1'b0;
      new_pc <= 32'h0;
    end else begin
      flush <= enter_flush;
      if (enter_flush)
        new_pc <= (excepttype_i == EXC_ERET) ? epc_i : EXC_VECTOR;
    end
  end

  // Stall mask: OR of sources, killed by reset, flush or a pending exception
  always_comb begin
    stall = 6'b000000;
    if (stallreq_id)                  stall = stall | 6'b000111;
    if (stallreq_ex)                  stall = stall | 6'b001111;
    if (state == IDLE && div_start)   stall = stall | 6'b001111;
    if (div_busy)                     stall = stall | 6'b001111;
    if (rst || flush || exc_hit)      stall = 6'b000000;
    stall[5:4] = 2'b00;
  end

  // Saturating count of pc-stall cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= 32'h0;
    else if (stall[0] && stall_cycles != 32'hFFFFFFFF)
      stall_cycles <= stall_cycles + 32'd1;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-age reference model of the pipeline controller.
module tb_pipe_ctrl;

  localparam int DIV_CYCLES = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id = 1'b0;
  logic        stallreq_ex = 1'b0;
  logic        div_start = 1'b0;
  logic [31:0] excepttype_i = 32'h0;
  logic [31:0] epc_i = 32'h0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        div_done;
  logic        div_busy;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_fail = 0;

  pipe_ctrl #(.DIV_CYCLES(DIV_CYCLES), .EXC_VECTOR(32'h00000020)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .div_start(div_start), .excepttype_i(excepttype_i), .epc_i(epc_i),
    .stall(stall), .flush(flush), .new_pc(new_pc), .div_done(div_done),
    .div_busy(div_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Reference model: m_age = cycles since the divide was accepted (0 = none)
  int          m_age;
  bit          m_flush;
  logic [31:0] m_pc;
  longint      m_sc;
  logic [5:0]  exp_stall;
  bit          exp_done, exp_busy, exp_flush;
  logic [31:0] exp_pc, exp_sc;

  task automatic model_reset();
    m_age = 0; m_flush = 0; m_pc = 32'h0; m_sc = 0;
  endtask

  // Drive one cycle's inputs at the falling edge, produce expectations,
  // then advance the model to what the next rising edge should do.
  task automatic run_cycle(input bit id, input bit ex, input bit ds,
                           input logic [31:0] exc, input logic [31:0] epc);
    bit in_div, idle;
    @(negedge clk);
    stallreq_id = id; stallreq_ex = ex; div_start = ds;
    excepttype_i = exc; epc_i = epc;
    #1;
    in_div    = m_age > 0;
    idle      = !in_div && !m_flush;
    exp_busy  = in_div && m_age < DIV_CYCLES;
    exp_done  = in_div && m_age == DIV_CYCLES && exc == 0;
    exp_flush = m_flush;
    exp_pc    = m_pc;
    exp_sc    = 32'(m_sc);
    exp_stall = 6'b0;
    if (id) exp_stall |= 6'b000111;
    if (ex) exp_stall |= 6'b001111;
    if (idle && ds) exp_stall |= 6'b001111;
    if (exp_busy) exp_stall |= 6'b001111;
    if (m_flush || exc != 0) exp_stall = 6'b0;
    if (exp_stall[0] && m_sc < 64'hFFFFFFFF) m_sc++;
    if (m_flush) begin
      m_flush = 0; m_age = 0;
    end else if (exc != 0) begin
      m_flush = 1; m_age = 0;
      m_pc = (exc == 32'h0000000e) ? epc : 32'h00000020;
    end else if (in_div) begin
      m_age = (m_age == DIV_CYCLES) ? 0 : m_age + 1;
    end else if (ds) begin
      m_age = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stallreq_id = 1'b1; div_start = 1'b1;
    #3;
    n_checks++;
    if (stall !== 6'b0 || div_done !== 1'b0 || div_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_comb: stall=%b done=%b busy=%b want 0", stall, div_done, div_busy);
    end
    n_checks++;
    if (flush !== 1'b0 || new_pc !== 32'h0 || stall_cycles !== 32'h0) begin
      n_fail++; $display("FAIL reset_regs: flush=%b pc=%h sc=%0d want 0", flush, new_pc, stall_cycles);
    end
    stallreq_id = 1'b0; div_start = 1'b0;
    @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  task automatic test_stall_id();
    run_cycle(1, 0, 0, 0, 0);
    n_checks++;
    if (stall !== 6'b000111) begin
      n_fail++; $display("FAIL id_stall: got %b want 000111", stall);
    end
    run_cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (stall !== 6'b0 || stall_cycles !== 32'd1) begin
      n_fail++; $display("FAIL id_release: stall=%b sc=%0d want 000000 / 1", stall, stall_cycles);
    end
  endtask

  task automatic test_stall_both();
    run_cycle(1, 1, 0, 0, 0);
    n_checks++;
    if (stall !== 6'b001111) begin
      n_fail++; $display("FAIL id_ex_stall: got %b want 001111", stall);
    end
    run_cycle(0, 0, 0, 0, 0);
  endtask

  task automatic test_divide();
    logic [31:0] sc0;
    int bad_stall, bad_done;
    sc0 = stall_cycles; bad_stall = 0; bad_done = 0;
    for (int c = 0; c < DIV_CYCLES; c++) begin
      run_cycle(0, 0, c == 0, 0, 0);
      if (stall !== 6'b001111) bad_stall++;
      if (div_done !== 1'b0) bad_done++;
    end
    n_checks++;
    if (bad_stall != 0) begin
      n_fail++; $display("FAIL div_stall: %0d cycles not 001111, want 0", bad_stall);
    end
    n_checks++;
    if (bad_done != 0) begin
      n_fail++; $display("FAIL div_early_done: %0d early pulses, want 0", bad_done);
    end
    run_cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (div_done !== 1'b1 || stall !== 6'b0 || div_busy !== 1'b0) begin
      n_fail++; $display("FAIL div_done_cycle: done=%b stall=%b busy=%b want 1/000000/0", div_done, stall, div_busy);
    end
    run_cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (div_done !== 1'b0 || stall_cycles - sc0 !== 32'd32) begin
      n_fail++; $display("FAIL div_count: done=%b delta=%0d want 0 / 32", div_done, stall_cycles - sc0);
    end
  endtask

  task automatic test_div_exception();
    int done_seen;
    done_seen = 0;
    for (int c = 0; c < 10; c++) run_cycle(0, 0, c == 0, 0, 0);
    run_cycle(0, 0, 0, 32'h8, 0);
    n_checks++;
    if (stall !== 6'b0 || div_done !== 1'b0) begin
      n_fail++; $display("FAIL exc_cycle: stall=%b done=%b want 000000/0", stall, div_done);
    end
    run_cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (flush !== 1'b1 || new_pc !== 32'h00000020) begin
      n_fail++; $display("FAIL exc_flush: flush=%b pc=%h want 1/00000020", flush, new_pc);
    end
    run_cycle(0, 0, 1, 0, 0);
    n_checks++;
    if (flush !== 1'b0 || stall !== 6'b001111 || div_busy !== 1'b0) begin
      n_fail++; $display("FAIL exc_idle: flush=%b stall=%b busy=%b want 0/001111/0", flush, stall, div_busy);
    end
    for (int c = 0; c < DIV_CYCLES + 2; c++) begin
      run_cycle(0, 0, 0, 0, 0);
      if (div_done !== exp_done) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) begin
      n_fail++; $display("FAIL exc_redo_done: %0d wrong div_done cycles, want 0", done_seen);
    end
  endtask

  task automatic test_eret();
    run_cycle(1, 0, 0, 32'h0000000e, 32'h00400104);
    n_checks++;
    if (stall !== 6'b0) begin
      n_fail++; $display("FAIL eret_stall: got %b want 000000", stall);
    end
    run_cycle(0, 0, 0, 32'h0000000e, 32'h0);
    n_checks++;
    if (flush !== 1'b1 || new_pc !== 32'h00400104) begin
      n_fail++; $display("FAIL eret_flush: flush=%b pc=%h want 1/00400104", flush, new_pc);
    end
    run_cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (flush !== 1'b0) begin
      n_fail++; $display("FAIL eret_one_cycle: flush=%b want 0", flush);
    end
  endtask

  task automatic test_reset_mid_div();
    int done_seen;
    done_seen = 0;
    for (int c = 0; c <= 5; c++) run_cycle(0, 0, c == 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (stall !== 6'b0 || div_busy !== 1'b0 || flush !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: stall=%b busy=%b flush=%b want 0", stall, div_busy, flush);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < DIV_CYCLES + 4; c++) begin
      run_cycle(0, 0, 0, 0, 0);
      if (div_done !== 1'b0 || div_busy !== 1'b0) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) begin
      n_fail++; $display("FAIL rst_no_done: %0d cycles with done/busy, want 0", done_seen);
    end
  endtask

  task automatic test_random();
    bit id, ex, ds;
    logic [31:0] exc, epc;
    int r;
    for (int c = 0; c < 3000; c++) begin
      id  = ($urandom_range(99) < 20);
      ex  = ($urandom_range(99) < 12);
      ds  = ($urandom_range(99) < 8);
      r   = $urandom_range(199);
      exc = (r < 3) ? 32'h0000000e : (r < 6) ? ($urandom() | 32'h1) : 32'h0;
      epc = $urandom();
      run_cycle(id, ex, ds, exc, epc);
      n_checks++;
      if (stall !== exp_stall || div_done !== exp_done || div_busy !== exp_busy) begin
        n_fail++; $display("FAIL rnd_comb c=%0d: stall=%b done=%b busy=%b want %b/%b/%b",
                           c, stall, div_done, div_busy, exp_stall, exp_done, exp_busy);
      end
      n_checks++;
      if (flush !== exp_flush || (exp_flush && new_pc !== exp_pc) || stall_cycles !== exp_sc) begin
        n_fail++; $display("FAIL rnd_reg c=%0d: flush=%b pc=%h sc=%0d want %b/%h/%0d",
                           c, flush, new_pc, stall_cycles, exp_flush, exp_pc, exp_sc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stall_id();
    test_stall_both();
    test_divide();
    test_div_exception();
    test_eret();
    test_reset_mid_div();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
